// File: rtl/sat_accum_stream.sv
// +--------------------------------------------------------------------------+
// | sat_accum_stream: streaming signed accumulator, P-bit saturation per step |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sat_accum_stream #(
  parameter int P = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [P-1:0] in_data,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_data,
  output logic         out_sat
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [P-1:0]  MAX_VAL  = {1'b0, {(P-1){1'b1}}};
  localparam logic [P-1:0]  MIN_VAL  = {1'b1, {(P-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [P-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_flag_q, sat_flag_d;
  logic [P-1:0]  out_data_q, out_data_d;
  logic          out_sat_q, out_sat_d;

  logic [P:0]    sum_ext;
  logic          clamped;
  logic [P-1:0]  sum_sat;

  // One guard bit is enough: a P+1-bit sum of two P-bit signed values never wraps,
  // so disagreement between the top two bits marks an out-of-range result.
  always_comb begin
    if (in_sub) begin
      sum_ext = {acc_q[P-1], acc_q} - {in_data[P-1], in_data};
    end else begin
      sum_ext = {acc_q[P-1], acc_q} + {in_data[P-1], in_data};
    end
    clamped = sum_ext[P] ^ sum_ext[P-1];
    if (!clamped) begin
      sum_sat = sum_ext[P-1:0];
    end else if (sum_ext[P]) begin
      sum_sat = MIN_VAL;
    end else begin
      sum_sat = MAX_VAL;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_flag_d = sat_flag_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d      = sum_sat;
          sat_flag_d = sat_flag_q | clamped;
          if (cnt_q == LAST_CNT) begin
            out_data_d = sum_sat;
            out_sat_d  = sat_flag_q | clamped;
            state_d    = HOLD;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // Result registers are left untouched so the last result stays visible.
        if (out_ready) begin
          state_d    = ACCUM;
          acc_d      = '0;
          sat_flag_d = 1'b0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_flag_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_flag_q <= sat_flag_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_sat_accum_stream.sv
// +--------------------------------------------------------------------------+
// | tb_sat_accum_stream: directed self-checking bench for sat_accum_stream    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sat_accum_stream;

  localparam int P = 8;
  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [P-1:0] in_data;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] out_data;
  logic         out_sat;

  int n_tests;
  int n_fail;

  sat_accum_stream #(.P(P), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic push(input logic s, input logic [P-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sub   = s;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run4(input string tag,
                      input logic [3:0] subs,
                      input logic [P-1:0] d0, input logic [P-1:0] d1,
                      input logic [P-1:0] d2, input logic [P-1:0] d3,
                      input logic [P-1:0] exp_data, input logic exp_sat);
    push(subs[0], d0);
    push(subs[1], d1);
    push(subs[2], d2);
    check({tag, "_pre_valid"}, {31'd0, out_valid}, 32'd0);
    push(subs[3], d3);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"},  {24'd0, out_data}, {24'd0, exp_data});
    check({tag, "_sat"},   {31'd0, out_sat}, {31'd0, exp_sat});
    check({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    out_ready = 1'b1;

    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_out_data",  {24'd0, out_data}, 32'd0);
    check("rst_out_sat",   {31'd0, out_sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain sum, then positive clamp, negative clamp, and subtracting the minimum.
    run4("t1", 4'b0000, 8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 1'b0);
    drain("t1");
    run4("t2", 4'b0000, 8'd124, 8'd4, 8'd0, 8'hFF, 8'd126, 1'b1);
    drain("t2");
    run4("t3", 4'b0111, 8'd127, 8'd1, 8'd1, 8'd5, 8'h85, 1'b1);
    drain("t3");
    run4("t4", 4'b0001, 8'h80, 8'd0, 8'd0, 8'd0, 8'd127, 1'b1);
    drain("t4");

    // Back-pressure: a held result must not move and offered operands must not be taken.
    out_ready = 1'b0;
    run4("t5", 4'b0000, 8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 1'b0);
    in_valid = 1'b1;
    in_sub   = 1'b1;
    in_data  = 8'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t5_hold_data",  {24'd0, out_data}, 32'd10);
      check("t5_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_release_valid", {31'd0, out_valid}, 32'd0);
    check("t5_keep_data",     {24'd0, out_data}, 32'd10);
    run4("t5b", 4'b0000, 8'd9, 8'd1, 8'd1, 8'd1, 8'd12, 1'b0);
    drain("t5b");

    // Asynchronous reset in the middle of a partial accumulation.
    push(1'b0, 8'd50);
    push(1'b0, 8'd50);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_data",  {24'd0, out_data}, 32'd0);
    check("t6_async_valid", {31'd0, out_valid}, 32'd0);
    check("t6_async_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run4("t6", 4'b0000, 8'd1, 8'd1, 8'd1, 8'd1, 8'd4, 1'b0);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
